// File: rtl/video_pkg.sv
// video_pkg: shared FSM type, default address map and status bit positions
// for the posted video write queue.
package video_pkg;

    typedef enum logic {ESPERA, ENVIO} estado_cola_t;

    localparam logic [31:0] BASE_VIDEO_DEF     = 32'h0000_1000;
    localparam int          PALABRAS_VIDEO_DEF = 1024;
    localparam logic [31:0] DIR_ESTADO_DEF     = 32'h0000_2000;

    localparam int BIT_VACIO    = 0;
    localparam int BIT_LLENO    = 1;
    localparam int BIT_DESBORDE = 2;
    localparam int BIT_ENVIO    = 3;
    localparam int BIT_CUENTA   = 8;

endpackage

// File: rtl/fifo_sincrona.sv
// fifo_sincrona: register-array FIFO, single clock, async active-low reset.
//   push/dato   : write an entry at the tail
//   pop         : drop the head entry
//   cabeza      : current head entry (all-zero after reset)
//   cuenta      : occupancy, 0..PROFUNDIDAD
//   lleno/vacio : full / empty, derived from cuenta so pointers may wrap freely
module fifo_sincrona #(
    parameter int ANCHO       = 42,
    parameter int PROFUNDIDAD = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ANCHO-1:0]               dato,
    output logic [ANCHO-1:0]               cabeza,
    output logic [$clog2(PROFUNDIDAD):0]   cuenta,
    output logic                           lleno,
    output logic                           vacio
);
    localparam int PW = $clog2(PROFUNDIDAD);
    localparam int CW = PW + 1;

    logic [ANCHO-1:0] mem [PROFUNDIDAD];
    logic [PW-1:0]    ptrEsc, ptrLec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROFUNDIDAD; i++) mem[i] <= '0;
            ptrEsc <= '0;
            ptrLec <= '0;
            cuenta <= '0;
        end else begin
            if (push) mem[ptrEsc] <= dato;
            ptrEsc <= push ? ptrEsc + PW'(1) : ptrEsc;
            ptrLec <= pop ? ptrLec + PW'(1) : ptrLec;
            cuenta <= cuenta + CW'(push) - CW'(pop);
        end
    end

    assign cabeza = mem[ptrLec];
    assign lleno  = cuenta == CW'(PROFUNDIDAD);
    assign vacio  = cuenta == '0;

endmodule

// File: rtl/cola_video_escritura.sv
// cola_video_escritura: posted-write queue from the CPU store path to the video
// tile RAM, drained only during blanking.
//   memWr/direc/datoOut : CPU store strobe, byte address, data
//   ventana             : blanking, tile RAM may be written
//   vidListo            : tile RAM accepts the current write
//   vidWr/vidAddr/vidData : write request to the tile RAM (FIFO head)
//   enVideo             : direc decodes to the video window or the status word
//   estado              : status word {count[15:8], envio, desborde, lleno, vacio}
module cola_video_escritura
    import video_pkg::*;
#(
    parameter int          PROFUNDIDAD    = 8,
    parameter logic [31:0] BASE_VIDEO     = BASE_VIDEO_DEF,
    parameter int          PALABRAS_VIDEO = PALABRAS_VIDEO_DEF,
    parameter logic [31:0] DIR_ESTADO     = DIR_ESTADO_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              memWr,
    input  logic [31:0]                       direc,
    input  logic [31:0]                       datoOut,
    input  logic                              ventana,
    input  logic                              vidListo,
    output logic                              vidWr,
    output logic [$clog2(PALABRAS_VIDEO)-1:0] vidAddr,
    output logic [31:0]                       vidData,
    output logic                              enVideo,
    output logic [31:0]                       estado
);
    localparam int          AW          = $clog2(PALABRAS_VIDEO);
    localparam int          CW          = $clog2(PROFUNDIDAD) + 1;
    localparam logic [31:0] TAM_VENTANA = 32'(4 * PALABRAS_VIDEO);

    estado_cola_t    estadoCola;
    logic [31:0]     desp;
    logic [AW+31:0]  cabeza;
    logic [CW-1:0]   cuenta;
    logic            enVentana, push, pop, lleno, vacio, desborde, desbordar, limpiar;

    assign desp      = direc - BASE_VIDEO;
    assign enVentana = (direc >= BASE_VIDEO) && (desp < TAM_VENTANA);
    assign enVideo   = enVentana || (direc == DIR_ESTADO);
    assign pop       = (estadoCola == ENVIO) && vidListo;
    // A full queue still accepts a store when the head leaves in the same cycle.
    assign push      = memWr && enVentana && (!lleno || pop);
    assign desbordar = memWr && enVentana && lleno && !pop;
    assign limpiar   = memWr && (direc == DIR_ESTADO) && datoOut[0];

    fifo_sincrona #(.ANCHO(AW + 32), .PROFUNDIDAD(PROFUNDIDAD)) uFifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .dato   ({desp[AW+1:2], datoOut}),
        .cabeza (cabeza),
        .cuenta (cuenta),
        .lleno  (lleno),
        .vacio  (vacio)
    );

    // Leaving ENVIO looks at the count after this edge's pop and push, so a
    // store landing on the last entry keeps the request up without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estadoCola <= ESPERA;
            desborde   <= 1'b0;
        end else begin
            desborde   <= desbordar || (desborde && !limpiar);
            estadoCola <= (estadoCola == ESPERA)
                ? ((!vacio && ventana) ? ENVIO : ESPERA)
                : ((vidListo && ((cuenta == CW'(1) && !push) || !ventana)) ? ESPERA : ENVIO);
        end
    end

    assign vidWr            = estadoCola == ENVIO;
    assign {vidAddr, vidData} = cabeza;

    always_comb begin
        estado                   = '0;
        estado[BIT_VACIO]        = vacio;
        estado[BIT_LLENO]        = lleno;
        estado[BIT_DESBORDE]     = desborde;
        estado[BIT_ENVIO]        = estadoCola == ENVIO;
        estado[BIT_CUENTA +: 8]  = 8'(cuenta);
    end

endmodule

// File: tb/tb_cola_video_escritura.sv
// tb_cola_video_escritura: directed plus randomized bench against a queue-based
// model of the video write queue.
module tb_cola_video_escritura;
    localparam int PROF = 8;
    localparam int PAL  = 1024;
    localparam int AW   = 10;

    logic          clk = 0, rst_n = 0, memWr = 0, ventana = 0, vidListo = 0;
    logic [31:0]   direc = 0, datoOut = 0;
    logic          vidWr, enVideo;
    logic [AW-1:0] vidAddr;
    logic [31:0]   vidData, estado;

    int checks = 0, errors = 0, nCiclo = 0;
    logic [AW+31:0] q[$];
    logic [AW+31:0] vistos[$];
    int             tiempos[$];
    bit             mOvf = 0, mBusy = 0;

    cola_video_escritura #(
        .PROFUNDIDAD(PROF), .BASE_VIDEO(32'h1000), .PALABRAS_VIDEO(PAL), .DIR_ESTADO(32'h2000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .memWr(memWr), .direc(direc), .datoOut(datoOut),
        .ventana(ventana), .vidListo(vidListo), .vidWr(vidWr), .vidAddr(vidAddr),
        .vidData(vidData), .enVideo(enVideo), .estado(estado)
    );

    always #5 clk = ~clk;

    function automatic bit enVentana(logic [31:0] a);
        return a >= 32'h1000 && a < 32'h1000 + 4 * PAL;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic rstModelo();
        q.delete();
        mOvf  = 0;
        mBusy = 0;
    endtask

    // One clock edge of the queue as seen from outside.
    task automatic modelo();
        int antes;
        bit sale;
        antes = q.size();
        sale  = mBusy && vidListo;
        if (sale) void'(q.pop_front());
        if (memWr && direc == 32'h2000 && datoOut[0]) mOvf = 0;
        if (memWr && enVentana(direc)) begin
            if (antes < PROF || sale) q.push_back({AW'((direc - 32'h1000) >> 2), datoOut});
            else mOvf = 1;
        end
        if (!mBusy) mBusy = antes > 0 && ventana;
        else if (vidListo && (q.size() == 0 || !ventana)) mBusy = 0;
    endtask

    task automatic comparar();
        logic [31:0] e;
        e       = 0;
        e[0]    = q.size() == 0;
        e[1]    = q.size() == PROF;
        e[2]    = mOvf;
        e[3]    = mBusy;
        e[15:8] = 8'(q.size());
        chk("estado", estado, e);
        chk("vidWr", vidWr, mBusy);
        if (mBusy) chk("cabeza", {vidAddr, vidData}, q[0]);
        chk("enVideo", enVideo, enVentana(direc) || direc == 32'h2000);
    endtask

    task automatic ciclo();
        if (vidWr && vidListo && rst_n) begin
            vistos.push_back({vidAddr, vidData});
            tiempos.push_back(nCiclo);
        end
        @(posedge clk);
        nCiclo++;
        if (rst_n) modelo();
        @(negedge clk);
        comparar();
    endtask

    task automatic drive(bit w, logic [31:0] a, logic [31:0] d, bit v, bit l);
        memWr = w; direc = a; datoOut = d; ventana = v; vidListo = l;
    endtask

    logic [31:0] bordes [5] = '{32'h0FFC, 32'h0FFF, 32'h1FFC, 32'h1FFF, 32'h2004};
    logic [31:0] a;
    int s;

    initial begin
        rstModelo();
        ciclo(); ciclo();
        chk("rst_estado", estado, 32'h1);
        chk("rst_vidWr", vidWr, 0);
        chk("rst_vidAddr", vidAddr, 0);
        chk("rst_vidData", vidData, 0);
        direc = 32'h0FFC; #1 chk("dec_0FFC", enVideo, 0);
        direc = 32'h1FFF; #1 chk("dec_1FFF", enVideo, 1);
        direc = 32'h2000; #1 chk("dec_2000", enVideo, 1);
        direc = 32'h2004; #1 chk("dec_2004", enVideo, 0);
        @(negedge clk);
        rst_n = 1;

        // single store drained immediately
        drive(1, 32'h1008, 32'hDEAD_BEEF, 1, 1); ciclo();
        chk("t1_cuenta", estado, 32'h100);
        drive(0, 0, 0, 1, 1); ciclo();
        chk("t1_vidWr", vidWr, 1);
        chk("t1_vidAddr", vidAddr, 2);
        chk("t1_vidData", vidData, 32'hDEAD_BEEF);
        ciclo();
        chk("t1_fin", estado, 32'h1);
        chk("t1_finWr", vidWr, 0);

        // fill past full with the display active
        for (int i = 0; i < 9; i++) begin
            drive(1, 32'h1000 + 4 * i, 32'hA0 + i, 0, 0); ciclo();
        end
        drive(0, 0, 0, 0, 0); ciclo();
        chk("t2_lleno", estado, 32'h0806);
        chk("t2_vidWr", vidWr, 0);

        // clear overflow, then back-to-back drain
        drive(1, 32'h2000, 32'h1, 0, 0); ciclo();
        chk("t3_limpia", estado, 32'h0802);
        drive(0, 0, 0, 1, 1);
        vistos.delete(); tiempos.delete();
        repeat (10) ciclo();
        chk("t3_n", vistos.size(), 8);
        if (vistos.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t3_orden", vistos[i], {AW'(i), 32'hA0 + i});
            chk("t3_seguidos", tiempos[7] - tiempos[0], 7);
        end

        // ventana falls mid-request: request held until vidListo
        drive(1, 32'h1010, 32'h55, 1, 0); ciclo();
        drive(0, 0, 0, 1, 0); ciclo();
        chk("t4_req", vidWr, 1);
        drive(0, 0, 0, 0, 0);
        repeat (3) begin
            ciclo();
            chk("t4_wr", vidWr, 1);
            chk("t4_addr", vidAddr, 4);
            chk("t4_data", vidData, 32'h55);
        end
        drive(0, 0, 0, 0, 1); ciclo();
        chk("t4_fin", estado, 32'h1);
        drive(0, 0, 0, 0, 0); ciclo();

        // push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1100 + 4 * i, 32'hB0 + i, 0, 0); ciclo();
        end
        drive(0, 0, 0, 1, 0); ciclo();
        chk("t5_envio", estado, 32'h080A);
        vistos.delete();
        drive(1, 32'h1200, 32'h77, 1, 1); ciclo();
        chk("t5_simul", estado, 32'h080A);
        drive(0, 0, 0, 1, 1);
        repeat (10) ciclo();
        chk("t5_n", vistos.size(), 9);
        chk("t5_ultimo", vistos.size() > 0 ? vistos[vistos.size() - 1] : '0, {10'h80, 32'h77});

        // asynchronous reset during a transfer
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1300 + 4 * i, 32'hC0 + i, 0, 0); ciclo();
        end
        drive(0, 0, 0, 1, 0); ciclo(); ciclo();
        chk("t6_req", vidWr, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_vidWr", vidWr, 0);
        chk("t6_estado", estado, 32'h1);
        chk("t6_vidAddr", vidAddr, 0);
        rstModelo();
        ciclo();
        rst_n = 1;
        drive(1, 32'h3000, 32'h99, 1, 1);
        #1 chk("t6_enVideo", enVideo, 0);
        ciclo(); ciclo();
        chk("t6_vacio", estado, 32'h1);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            s = $urandom_range(0, 9);
            if (s < 6) a = 32'h1000 + ($urandom_range(0, PAL - 1) << 2) + $urandom_range(0, 3);
            else if (s == 6) a = 32'h2000;
            else if (s == 7) a = bordes[$urandom_range(0, 4)];
            else a = $urandom;
            drive($urandom_range(0, 1), a, $urandom,
                  ((n / 25) % 2) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                rstModelo();
                ciclo();
                rst_n = 1;
            end else ciclo();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
